writeback_gen: RTL and testbench

Parametrised writeback stage, successor to the fixed two-port writeback.
- Retires NPORTS results per cycle.
- Aligns load data and zero- or sign-extends it.
- Classifies the retiring instruction's events: exceptions, interrupts, rfe/rfi, halt, sleep.
- Owns a RUN/SLEEP/HALT state machine that freezes retirement.
- Holds a HIST_DEPTH-deep history of committed writes, used for decode/execute bypass.
- Sits after the memory stage and drives the register-file write ports and the forwarding network.

---
 rtl/writeback_gen_pkg.sv | 47 ++++
 rtl/writeback_gen_load_align.sv | 52 +++++
 rtl/writeback_gen.sv | 181 ++++++++++++++++++
 tb/tb_writeback_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_gen_pkg.sv
// writeback_gen_pkg
//   Shared constants and types for the parametrised writeback stage:
//   opcode / privileged sub-type encodings, TLB exception codes, the
//   RUN/SLEEP/HALT state encoding and the load-size encoding.
package writeback_gen_pkg;

    // Opcodes seen at writeback
    localparam logic [4:0] OP_PRIV    = 5'd31;  // privileged group (rfe/rfi/halt/sleep)
    localparam logic [4:0] OP_BRI     = 5'd12;  // branch-immediate, never writes a register
    localparam logic [4:0] OP_LOAD_LO = 5'd16;  // load opcode range, inclusive
    localparam logic [4:0] OP_LOAD_HI = 5'd23;

    // Privileged sub-types (priv_type)
    localparam logic [4:0] PRIV_HALT  = 5'd2;   // halt or sleep, chosen by crmov_mode_type
    localparam logic [4:0] PRIV_RFE   = 5'd3;

    // crmov_mode_type values qualifying PRIV_HALT
    localparam logic [1:0] MODE_SLEEP = 2'd1;
    localparam logic [1:0] MODE_HALT  = 2'd2;

    // TLB exception codes
    localparam logic [7:0] EXC_TLB_I  = 8'h82;
    localparam logic [7:0] EXC_TLB_D  = 8'h83;

    // Retirement state machine encoding (also the state_out encoding)
    typedef logic [1:0] wb_state_t;
    localparam wb_state_t ST_RUN   = 2'd0;
    localparam wb_state_t ST_SLEEP = 2'd1;
    localparam wb_state_t ST_HALT  = 2'd2;

    // load_size encoding; LS_NONE yields a zero result
    typedef enum logic [1:0] {
        LS_WORD = 2'd0,
        LS_HALF = 2'd1,
        LS_BYTE = 2'd2,
        LS_NONE = 2'd3
    } load_size_e;

    function automatic logic is_tlb_exc(input logic [7:0] code);
        return (code == EXC_TLB_I) || (code == EXC_TLB_D);
    endfunction

    function automatic logic is_load_opcode(input logic [4:0] op);
        return (op >= OP_LOAD_LO) && (op <= OP_LOAD_HI);
    endfunction

endpackage

// File: rtl/writeback_gen_load_align.sv
// writeback_gen_load_align
//   Purely combinational load-data aligner. Picks a word, half or byte
//   out of the low 32 bits of the raw memory word according to size and
//   addr_lo, then zero- or sign-extends it to XLEN.
// Ports:
//   data      in  XLEN  raw memory word (only [31:0] is examined)
//   size      in  2     0 word, 1 half, 2 byte, 3 -> result 0
//   sign_ext  in  1     sign-extend the selected field
//   addr_lo   in  2     low address bits selecting the field
//   aligned   out XLEN  aligned, extended result
module writeback_gen_load_align
    import writeback_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] aligned
);

    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;

    assign w = data[31:0];

    // A half at offset 3 would straddle the word; it is treated as offset 2.
    always_comb begin
        h = w[31:16];
        case (addr_lo)
            2'd0:    h = w[15:0];
            2'd1:    h = w[23:8];
            default: h = w[31:16];
        endcase
    end

    assign b = w[{addr_lo, 3'b000} +: 8];

    // Size casts of a signed operand sign-extend; of an unsigned one zero-extend.
    always_comb begin
        aligned = '0;
        case (load_size_e'(size))
            LS_WORD: aligned = sign_ext ? XLEN'($signed(w)) : XLEN'(w);
            LS_HALF: aligned = sign_ext ? XLEN'($signed(h)) : XLEN'(h);
            LS_BYTE: aligned = sign_ext ? XLEN'($signed(b)) : XLEN'(b);
            default: aligned = '0;
        endcase
    end

endmodule

// File: rtl/writeback_gen.sv
// writeback_gen
//   Parametrised writeback stage. Retires NPORTS results per cycle, aligns
//   load data on port 0, classifies the retiring slot's events, runs the
//   RUN/SLEEP/HALT retirement state machine and keeps a HIST_DEPTH-deep
//   history of committed writes for the bypass network.
//   XLEN must be 32 or 64; NPORTS 1..4; HIST_DEPTH 1..4.
// Ports:
//   clk, rst_n (async, active low), clk_en (global advance)
//   bubble_in, opcode, priv_type, crmov_mode_type, exc_in   slot decode
//   is_load, is_store, tgts_cr, load_size, load_signed,
//   addr_lo, mem_result                                     port-0 memory path
//   alu_result, tgt_in                                      per-port flat buses
//   wake_irq                                                SLEEP wakeup (level)
//   result_out, we                                          combinational write ports
//   wb_tgt_out, wb_result_out, wb_valid_out                 registered write ports
//   hist_valid, hist_tgt, hist_result                       history; entry k, port p
//                                                           at flat slot k*NPORTS+p
//   exc/interrupt/rfe/rfi/tlb_exc_in_wb                     event flags
//   halt_out, sleep_out                                     one-cycle event pulses
//   state_out                                               0 RUN, 1 SLEEP, 2 HALT
module writeback_gen
    import writeback_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NPORTS     = 2,
    parameter int REG_BITS   = 5,
    parameter int HIST_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clk_en,
    input  logic                                 bubble_in,
    input  logic [4:0]                           opcode,
    input  logic [4:0]                           priv_type,
    input  logic [1:0]                           crmov_mode_type,
    input  logic [7:0]                           exc_in,
    input  logic                                 is_load,
    input  logic                                 is_store,
    input  logic                                 tgts_cr,
    input  logic [1:0]                           load_size,
    input  logic                                 load_signed,
    input  logic [1:0]                           addr_lo,
    input  logic [XLEN-1:0]                      mem_result,
    input  logic [NPORTS*XLEN-1:0]               alu_result,
    input  logic [NPORTS*REG_BITS-1:0]           tgt_in,
    input  logic                                 wake_irq,
    output logic [NPORTS*XLEN-1:0]               result_out,
    output logic [NPORTS-1:0]                    we,
    output logic [NPORTS*REG_BITS-1:0]           wb_tgt_out,
    output logic [NPORTS*XLEN-1:0]               wb_result_out,
    output logic [NPORTS-1:0]                    wb_valid_out,
    output logic [NPORTS*HIST_DEPTH-1:0]         hist_valid,
    output logic [NPORTS*HIST_DEPTH*REG_BITS-1:0] hist_tgt,
    output logic [NPORTS*HIST_DEPTH*XLEN-1:0]    hist_result,
    output logic                                 exc_in_wb,
    output logic                                 interrupt_in_wb,
    output logic                                 rfe_in_wb,
    output logic                                 rfi_in_wb,
    output logic                                 tlb_exc_in_wb,
    output logic                                 halt_out,
    output logic                                 sleep_out,
    output logic [1:0]                           state_out
);

    wb_state_t state;
    logic      live;
    logic      priv_ok;
    logic      retire_ok;
    logic      advance;
    logic [XLEN-1:0] aligned;

    // History storage; entry 0 is the newest. Packed so the flat output
    // buses are a straight reinterpretation.
    logic [HIST_DEPTH-1:0][NPORTS-1:0]          h_vld;
    logic [HIST_DEPTH-1:0][NPORTS*REG_BITS-1:0] h_tgt;
    logic [HIST_DEPTH-1:0][NPORTS*XLEN-1:0]     h_res;

    // ---------------------------------------------------------------
    // Event classification
    // ---------------------------------------------------------------
    assign live            = !bubble_in && (state == ST_RUN);
    assign exc_in_wb       = live && (exc_in != '0);
    assign interrupt_in_wb = live && (exc_in[7:4] == 4'hf);
    assign tlb_exc_in_wb   = exc_in_wb && is_tlb_exc(exc_in);

    // Privileged encodings only count when the slot is not faulting, so an
    // exception in a halt/sleep slot also blocks the state transition.
    assign priv_ok   = live && !exc_in_wb && (opcode == OP_PRIV);
    assign rfe_in_wb = priv_ok && (priv_type == PRIV_RFE);
    assign rfi_in_wb = rfe_in_wb && crmov_mode_type[1];
    assign halt_out  = priv_ok && (priv_type == PRIV_HALT) && (crmov_mode_type == MODE_HALT);
    assign sleep_out = priv_ok && (priv_type == PRIV_HALT) && (crmov_mode_type == MODE_SLEEP);

    assign retire_ok = live && !exc_in_wb && (opcode != OP_BRI);

    // ---------------------------------------------------------------
    // Load alignment (port 0 only)
    // ---------------------------------------------------------------
    writeback_gen_load_align #(.XLEN(XLEN)) u_align (
        .data     (mem_result),
        .size     (load_size),
        .sign_ext (load_signed),
        .addr_lo  (addr_lo),
        .aligned  (aligned)
    );

    // ---------------------------------------------------------------
    // Per-port result mux and write enables
    // ---------------------------------------------------------------
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [REG_BITS-1:0] tgt;
        assign tgt = tgt_in[p*REG_BITS +: REG_BITS];

        if (p == 0) begin : g_ld
            // Port 0 carries loads, stores and control-register moves; the
            // latter two never write the integer register file.
            assign result_out[0 +: XLEN] = is_load ? aligned : alu_result[0 +: XLEN];
            assign we[0] = retire_ok && (tgt != '0) && !is_store && !tgts_cr;
        end else begin : g_alu
            assign result_out[p*XLEN +: XLEN] = alu_result[p*XLEN +: XLEN];
            assign we[p] = retire_ok && (tgt != '0);
        end
    end

    // ---------------------------------------------------------------
    // Retirement state machine
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (clk_en) begin
            case (state)
                ST_RUN: begin
                    if (halt_out)       state <= ST_HALT;
                    else if (sleep_out) state <= ST_SLEEP;
                end
                // wake_irq is only looked at from SLEEP, so a wake that
                // coincides with the sleep slot is ignored.
                ST_SLEEP: if (wake_irq) state <= ST_RUN;
                default:  state <= state;   // HALT exits only via reset
            endcase
        end
    end

    assign state_out = state;

    // ---------------------------------------------------------------
    // Registered write ports and history
    // ---------------------------------------------------------------
    assign advance = clk_en && (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_out  <= '0;
            wb_tgt_out    <= '0;
            wb_result_out <= '0;
            h_vld         <= '0;
            h_tgt         <= '0;
            h_res         <= '0;
        end else if (advance) begin
            // Entering SLEEP/HALT drops the registered enables so nothing
            // downstream keeps forwarding a stale write while frozen.
            wb_valid_out  <= (halt_out || sleep_out) ? '0 : we;
            wb_tgt_out    <= tgt_in;
            wb_result_out <= result_out;
            for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                h_vld[k] <= h_vld[k-1];
                h_tgt[k] <= h_tgt[k-1];
                h_res[k] <= h_res[k-1];
            end
            h_vld[0] <= wb_valid_out;
            h_tgt[0] <= wb_tgt_out;
            h_res[0] <= wb_result_out;
        end
    end

    assign hist_valid  = h_vld;
    assign hist_tgt    = h_tgt;
    assign hist_result = h_res;

endmodule

// File: tb/tb_writeback_gen.sv
// tb_writeback_gen
//   Directed-vector bench for writeback_gen (XLEN 32, two ports, two-deep
//   history). A behavioural model derives every output from the block's
//   rules and is compared on each falling edge; literal expectations at
//   key points pin the model itself.
module tb_writeback_gen;

    localparam int XLEN = 32;
    localparam int NP   = 2;
    localparam int RB   = 5;
    localparam int HD   = 2;

    logic clk = 1'b0;
    logic rst_n, clk_en, bubble_in, is_load, is_store, tgts_cr, load_signed, wake_irq;
    logic [4:0] opcode, priv_type;
    logic [1:0] crmov_mode_type, load_size, addr_lo;
    logic [7:0] exc_in;
    logic [XLEN-1:0] mem_result;
    logic [NP*XLEN-1:0] alu_result, result_out, wb_result_out;
    logic [NP*RB-1:0] tgt_in, wb_tgt_out;
    logic [NP-1:0] we, wb_valid_out;
    logic [NP*HD-1:0] hist_valid;
    logic [NP*HD*RB-1:0] hist_tgt;
    logic [NP*HD*XLEN-1:0] hist_result;
    logic exc_in_wb, interrupt_in_wb, rfe_in_wb, rfi_in_wb, tlb_exc_in_wb, halt_out, sleep_out;
    logic [1:0] state_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_gen #(.XLEN(XLEN), .NPORTS(NP), .REG_BITS(RB), .HIST_DEPTH(HD)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bubble_in(bubble_in),
        .opcode(opcode), .priv_type(priv_type), .crmov_mode_type(crmov_mode_type),
        .exc_in(exc_in), .is_load(is_load), .is_store(is_store), .tgts_cr(tgts_cr),
        .load_size(load_size), .load_signed(load_signed), .addr_lo(addr_lo),
        .mem_result(mem_result), .alu_result(alu_result), .tgt_in(tgt_in),
        .wake_irq(wake_irq), .result_out(result_out), .we(we),
        .wb_tgt_out(wb_tgt_out), .wb_result_out(wb_result_out), .wb_valid_out(wb_valid_out),
        .hist_valid(hist_valid), .hist_tgt(hist_tgt), .hist_result(hist_result),
        .exc_in_wb(exc_in_wb), .interrupt_in_wb(interrupt_in_wb), .rfe_in_wb(rfe_in_wb),
        .rfi_in_wb(rfi_in_wb), .tlb_exc_in_wb(tlb_exc_in_wb), .halt_out(halt_out),
        .sleep_out(sleep_out), .state_out(state_out)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_state;            // 0 RUN, 1 SLEEP, 2 HALT
    logic [NP-1:0] m_wbv;
    logic [NP*RB-1:0] m_wbt;
    logic [NP*XLEN-1:0] m_wbr;
    logic [NP*HD-1:0] m_hv;
    logic [NP*HD*RB-1:0] m_ht;
    logic [NP*HD*XLEN-1:0] m_hr;

    logic e_live, e_exc, e_int, e_tlb, e_rfe, e_rfi, e_halt, e_sleep;
    logic [63:0] e_f;
    int e_bits;
    logic [RB-1:0] e_t;
    logic [NP-1:0] e_we;
    logic [NP*XLEN-1:0] e_result;

    always_comb begin
        e_live  = !bubble_in && m_state == 2'd0;
        e_exc   = e_live && exc_in != 8'h00;
        e_int   = e_live && exc_in[7:4] == 4'hf;
        e_tlb   = e_exc && (exc_in == 8'h82 || exc_in == 8'h83);
        e_rfe   = e_live && !e_exc && opcode == 5'd31 && priv_type == 5'd3;
        e_rfi   = e_rfe && crmov_mode_type[1];
        e_halt  = e_live && !e_exc && opcode == 5'd31 && priv_type == 5'd2 && crmov_mode_type == 2'd2;
        e_sleep = e_live && !e_exc && opcode == 5'd31 && priv_type == 5'd2 && crmov_mode_type == 2'd1;
        // load field: shift the wanted bytes down, mask, then extend
        e_f    = {32'h0, mem_result[31:0]};
        e_bits = 32;
        case (load_size)
            2'd1: begin
                e_f = (e_f >> ((addr_lo == 2'd0) ? 0 : (addr_lo == 2'd1) ? 8 : 16)) & 64'hFFFF;
                e_bits = 16;
            end
            2'd2: begin e_f = (e_f >> (8 * addr_lo)) & 64'hFF; e_bits = 8; end
            2'd3: begin e_f = 64'h0; e_bits = 0; end
            default: ;
        endcase
        if (load_signed && e_bits > 0 && e_f[e_bits-1]) e_f = e_f | ~((64'd1 << e_bits) - 64'd1);
        e_result = alu_result;
        if (is_load) e_result[XLEN-1:0] = e_f[XLEN-1:0];
        e_t  = '0;
        e_we = '0;
        for (int p = 0; p < NP; p++) begin
            e_t = tgt_in[p*RB +: RB];
            e_we[p] = e_live && !e_exc && e_t != '0 && opcode != 5'd12 &&
                      (p != 0 || (!is_store && !tgts_cr));
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 2'd0; m_wbv <= '0; m_wbt <= '0; m_wbr <= '0;
            m_hv <= '0; m_ht <= '0; m_hr <= '0;
        end else if (clk_en) begin
            if (m_state == 2'd0) begin
                m_wbv <= (e_halt || e_sleep) ? '0 : e_we;
                m_wbt <= tgt_in;
                m_wbr <= e_result;
                // history as one flat word: push newest at the bottom, oldest falls off
                m_hv  <= (m_hv << NP) | (NP*HD)'(m_wbv);
                m_ht  <= (m_ht << (NP*RB)) | (NP*HD*RB)'(m_wbt);
                m_hr  <= (m_hr << (NP*XLEN)) | (NP*HD*XLEN)'(m_wbr);
                if (e_halt)       m_state <= 2'd2;
                else if (e_sleep) m_state <= 2'd1;
            end else if (m_state == 2'd1 && wake_irq) begin
                m_state <= 2'd0;
            end
        end
    end

    always @(negedge clk) begin
        check("result_out", result_out, e_result);
        check("we", we, e_we);
        check("flags", {exc_in_wb, interrupt_in_wb, tlb_exc_in_wb, rfe_in_wb, rfi_in_wb, halt_out, sleep_out},
              {e_exc, e_int, e_tlb, e_rfe, e_rfi, e_halt, e_sleep});
        check("state_out", state_out, m_state);
        check("wb_valid", wb_valid_out, m_wbv);
        check("wb_tgt", wb_tgt_out, m_wbt);
        check("wb_result", wb_result_out, m_wbr);
        check("hist_valid", hist_valid, m_hv);
        check("hist_tgt", hist_tgt, m_ht);
        check("hist_result", hist_result, m_hr);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        bubble_in = 1'b1; opcode = '0; priv_type = '0; crmov_mode_type = '0; exc_in = '0;
        is_load = 1'b0; is_store = 1'b0; tgts_cr = 1'b0; load_size = '0; load_signed = 1'b0;
        addr_lo = '0; mem_result = '0; alu_result = '0; tgt_in = '0; wake_irq = 1'b0;
    endtask

    task automatic alu(input logic [4:0] t1, input logic [4:0] t0,
                       input logic [31:0] r1, input logic [31:0] r0);
        clr();
        bubble_in = 1'b0; tgt_in = {t1, t0}; alu_result = {r1, r0};
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [1:0] a, input logic [31:0] m);
        clr();
        bubble_in = 1'b0; is_load = 1'b1; opcode = 5'd16; load_size = sz; load_signed = sg;
        addr_lo = a; mem_result = m; tgt_in = {5'd0, 5'd4}; alu_result = {32'h0, 32'hDEAD};
    endtask

    task automatic priv(input logic [4:0] pt, input logic [1:0] cm);
        clr();
        bubble_in = 1'b0; opcode = 5'd31; priv_type = pt; crmov_mode_type = cm;
    endtask

    initial begin
        clk_en = 1'b1;
        clr();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_state", state_out, 2'd0);
        check("rst_wb_valid", wb_valid_out, 2'b00);
        check("rst_hist_valid", hist_valid, 4'h0);
        tick(); tick();
        rst_n = 1'b1;

        // load alignment
        ld(2'd2, 1'b1, 2'd3, 32'h8081_F07F); #1;
        check("ld_b3_signed", result_out[31:0], 32'hFFFF_FF80);
        check("ld_we0", we[0], 1'b1);
        tick();
        ld(2'd2, 1'b0, 2'd3, 32'h8081_F07F); #1;
        check("ld_b3_unsigned", result_out[31:0], 32'h0000_0080);
        tick();
        ld(2'd1, 1'b1, 2'd1, 32'h8081_F07F); #1;
        check("ld_h1_signed", result_out[31:0], 32'hFFFF_81F0);
        tick();
        ld(2'd1, 1'b0, 2'd3, 32'h8081_F07F); #1;
        check("ld_h3_unsigned", result_out[31:0], 32'h0000_8081);
        tick();
        ld(2'd0, 1'b1, 2'd0, 32'h8081_F07F); #1;
        check("ld_word", result_out[31:0], 32'h8081_F07F);
        tick();
        ld(2'd2, 1'b1, 2'd0, 32'h8081_F07F); #1;
        check("ld_b0_signed", result_out[31:0], 32'h0000_007F);
        tick();
        ld(2'd3, 1'b1, 2'd0, 32'h8081_F07F); #1;
        check("ld_size3", result_out[31:0], 32'h0);
        tick();

        // two-port retire, then wb and history latency
        alu(5'd7, 5'd3, 32'hAA, 32'hBB); #1;
        check("two_port_we", we, 2'b11);
        tick();
        clr(); #1;
        check("wb_result_1cyc", wb_result_out, {32'hAA, 32'hBB});
        check("wb_tgt_1cyc", wb_tgt_out, {5'd7, 5'd3});
        check("wb_valid_1cyc", wb_valid_out, 2'b11);
        tick(); #1;
        check("hist0_result", hist_result[63:0], {32'hAA, 32'hBB});
        check("hist0_tgt", hist_tgt[9:0], {5'd7, 5'd3});
        check("hist0_valid", hist_valid[1:0], 2'b11);

        // store / bri / exceptions / rfe
        alu(5'd9, 5'd5, 32'h1, 32'h2); is_store = 1'b1; #1;
        check("store_we", we, 2'b10);
        tick();
        alu(5'd9, 5'd5, 32'h1, 32'h2); opcode = 5'd12; #1;
        check("bri_we", we, 2'b00);
        tick();
        alu(5'd9, 5'd5, 32'h1, 32'h2); exc_in = 8'h82; #1;
        check("tlb_flag", {exc_in_wb, tlb_exc_in_wb}, 2'b11);
        check("tlb_we", we, 2'b00);
        tick();
        alu(5'd9, 5'd5, 32'h1, 32'h2); exc_in = 8'hF3; #1;
        check("irq_flags", {interrupt_in_wb, tlb_exc_in_wb}, 2'b10);
        tick();
        priv(5'd3, 2'd2); #1;
        check("rfi", {rfe_in_wb, rfi_in_wb}, 2'b11);
        tick();
        priv(5'd3, 2'd0); #1;
        check("rfe_only", {rfe_in_wb, rfi_in_wb}, 2'b10);
        tick();
        priv(5'd2, 2'd2); exc_in = 8'h05; #1;
        check("halt_exc", halt_out, 1'b0);
        tick();
        clr(); #1;
        check("halt_exc_state", state_out, 2'd0);

        // clock-enable freeze
        alu(5'd2, 5'd1, 32'h11, 32'h22); tick();
        alu(5'd4, 5'd3, 32'h33, 32'h44); tick();
        clk_en = 1'b0;
        alu(5'd6, 5'd6, 32'h66, 32'h77);
        for (int i = 0; i < 3; i++) tick();
        check("freeze_wb_result", wb_result_out, {32'h33, 32'h44});
        check("freeze_wb_tgt", wb_tgt_out, {5'd4, 5'd3});
        check("freeze_hist0", hist_result[63:0], {32'h11, 32'h22});
        clk_en = 1'b1;
        tick();

        // sleep, then wake
        priv(5'd2, 2'd1); tgt_in = {5'd0, 5'd8}; #1;
        check("sleep_pulse", {sleep_out, halt_out}, 2'b10);
        tick();
        alu(5'd7, 5'd3, 32'h5, 32'h6);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("sleep_we", we, 2'b00);
            check("sleep_state", state_out, 2'd1);
            tick();
        end
        wake_irq = 1'b1;
        tick();
        wake_irq = 1'b0; #1;
        check("wake_state", state_out, 2'd0);
        check("wake_we", we, 2'b11);
        tick();
        // sleep and wake in the same slot: sleeps, a held wake then resumes
        priv(5'd2, 2'd1); wake_irq = 1'b1;
        tick(); #1;
        check("sleep_wake_same", state_out, 2'd1);
        tick(); #1;
        check("sleep_wake_held", state_out, 2'd0);
        clr();
        tick();

        // halt; only reset recovers
        priv(5'd2, 2'd2); #1;
        check("halt_pulse", {halt_out, sleep_out}, 2'b10);
        tick();
        alu(5'd5, 5'd5, 32'h9, 32'h9); wake_irq = 1'b1; #1;
        check("halt_state", state_out, 2'd2);
        check("halt_we", we, 2'b00);
        tick(); tick(); #1;
        check("halt_stuck", state_out, 2'd2);
        rst_n = 1'b0; #1;
        check("arst_state", state_out, 2'd0);
        check("arst_wb", {wb_valid_out, wb_tgt_out, wb_result_out}, '0);
        check("arst_hist_valid", hist_valid, 4'h0);
        check("arst_hist", {hist_tgt, hist_result}, '0);
        tick();
        rst_n = 1'b1;
        clr();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
